// File: rtl/cpu_branch_pkg.sv
// Shared types and branch classification for the BTB update queue.
package cpu_branch_pkg;

  localparam int unsigned BRANCH_XLEN         = 32;
  localparam int unsigned DEFAULT_INSTR_BYTES = 4;

  typedef struct packed {
    logic [BRANCH_XLEN-1:0] pc;
    logic [BRANCH_XLEN-1:0] target;
  } bupd_entry_t;

  typedef struct packed {
    logic mispredict;
    logic need_upd;
  } branch_class_t;

  // target_match compares predicted against actual taken target.
  function automatic branch_class_t classify_branch(input logic taken,
                                                    input logic pred_hit,
                                                    input logic target_match);
    branch_class_t c;
    c.mispredict = (pred_hit != taken) || (taken && !target_match);
    c.need_upd   = taken && (!pred_hit || !target_match);
    return c;
  endfunction

endpackage

// File: rtl/cpu_branch_update_queue_if.sv
// Execute-to-queue resolution bus plus BTB update port.
interface cpu_branch_update_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_pc;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_pred_hit;
  logic [XLEN-1:0] res_pred_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_stall;
  logic            update;
  logic [XLEN-1:0] update_addr;
  logic [XLEN-1:0] update_target_addr;

  modport master (
    output res_valid, res_pc, res_taken, res_target, res_pred_hit, res_pred_target, upd_stall,
    input  res_ready, redirect, redirect_pc, update, update_addr, update_target_addr
  );

  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_pred_hit, res_pred_target, upd_stall,
    output res_ready, redirect, redirect_pc, update, update_addr, update_target_addr
  );
endinterface

// File: rtl/cpu_branch_update_fifo.sv
// Small FIFO of BTB training entries with a merge-into-tail write port.
module cpu_branch_update_fifo
  import cpu_branch_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter type         entry_t     = bupd_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   merge,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t head,
  output logic   tail_hit,
  output logic   full,
  output logic   empty,
  output logic   one_left
);
  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

  typedef logic [DEPTH_WIDTH:0] ptr_t;

  ptr_t                   wptr_q, rptr_q;
  ptr_t                   used;
  logic [DEPTH_WIDTH-1:0] tail_idx;
  entry_t                 mem_q [DEPTH];

  assign used     = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = ((wptr_q ^ rptr_q) == {1'b1, {DEPTH_WIDTH{1'b0}}});
  assign one_left = (used == ptr_t'(1));
  assign tail_idx = wptr_q[DEPTH_WIDTH-1:0] - DEPTH_WIDTH'(1);
  assign head     = mem_q[rptr_q[DEPTH_WIDTH-1:0]];
  assign tail_hit = !empty && (mem_q[tail_idx].pc == wdata.pc);

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[DEPTH_WIDTH-1:0]] <= wdata;
    end else if (merge) begin
      mem_q[tail_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ptr_t'(1);
      if (pop)  rptr_q <= rptr_q + ptr_t'(1);
    end
  end

endmodule

// File: rtl/cpu_branch_update_queue.sv
// Branch resolution: registered redirect plus buffered BTB training writes.
// Optional CPU_BRANCH_UPDATE_STATS_EN adds saturating resolve/mispredict/merge counters.
module cpu_branch_update_queue
  import cpu_branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter int unsigned INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CPU_BRANCH_UPDATE_STATS_EN
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispredict,
  output logic [31:0] stat_merged,
`endif
  cpu_branch_update_queue_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  branch_class_t   cls;
  entry_t          wdata, head;
  logic            accept, pop, push, merge;
  logic            tail_hit, full, empty, one_left;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q, next_pc;

  assign accept       = bus.res_valid && !full;
  assign cls          = classify_branch(bus.res_taken, bus.res_pred_hit,
                                        bus.res_pred_target == bus.res_target);
  assign pop          = !empty && !bus.upd_stall;
  // Never merge into an entry leaving the queue this cycle.
  assign merge        = accept && cls.need_upd && tail_hit && !(pop && one_left);
  assign push         = accept && cls.need_upd && !merge;
  assign wdata.pc     = bus.res_pc;
  assign wdata.target = bus.res_target;
  assign next_pc      = bus.res_taken ? bus.res_target : bus.res_pc + XLEN'(INSTR_BYTES);

  cpu_branch_update_fifo #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .entry_t     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .merge    (merge),
    .pop      (pop),
    .wdata    (wdata),
    .head     (head),
    .tail_hit (tail_hit),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= accept && cls.mispredict;
      if (accept && cls.mispredict) redirect_pc_q <= next_pc;
    end
  end

  assign bus.res_ready          = !full;
  assign bus.redirect           = redirect_q;
  assign bus.redirect_pc        = redirect_pc_q;
  assign bus.update             = pop;
  assign bus.update_addr        = head.pc;
  assign bus.update_target_addr = head.target;

`ifdef CPU_BRANCH_UPDATE_STATS_EN
  logic [31:0] resolved_q, mispredict_q, merged_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_q   <= '0;
      mispredict_q <= '0;
      merged_q     <= '0;
    end else begin
      if (accept && (resolved_q != '1))                     resolved_q   <= resolved_q + 32'd1;
      if (accept && cls.mispredict && (mispredict_q != '1)) mispredict_q <= mispredict_q + 32'd1;
      if (merge && (merged_q != '1))                        merged_q     <= merged_q + 32'd1;
    end
  end

  assign stat_resolved   = resolved_q;
  assign stat_mispredict = mispredict_q;
  assign stat_merged     = merged_q;
`endif

endmodule

// File: tb/tb_cpu_branch_update_queue.sv
// Scoreboard bench: driver runs a queue-level model, monitor compares on negedge.
module tb_cpu_branch_update_queue;
  localparam int unsigned XLEN = 32;

  typedef struct {
    int unsigned cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_branch_update_queue_if #(.XLEN(XLEN)) bus ();

  cpu_branch_update_queue #(
    .XLEN        (XLEN),
    .DEPTH_WIDTH (2),
    .INSTR_BYTES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_redir[$];
  exp_t exp_upd[$];
  ent_t model[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's view of that cycle.
  task automatic step(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                      input bit hit, input logic [31:0] pt, input bit stall, input bit r,
                      output bit acc);
    bit   pop, ready, mis, need;
    ent_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.res_valid       = v;
    bus.res_pc          = pc;
    bus.res_taken       = tk;
    bus.res_target      = tg;
    bus.res_pred_hit    = hit;
    bus.res_pred_target = pt;
    bus.upd_stall       = stall;
    ready = (model.size() < 4);
    if (mon_en) chk("res_ready", {31'd0, bus.res_ready}, {31'd0, ready});
    pop = (model.size() > 0) && !stall;
    if (pop) exp_upd.push_back('{cyc, model[0].pc, model[0].target});
    acc = 1'b0;
    if (r) begin
      model.delete();
      while (exp_redir.size() > 0 && exp_redir[exp_redir.size()-1].cyc > cyc)
        void'(exp_redir.pop_back());
      return;
    end
    acc = v && ready;
    if (acc) begin
      mis  = (hit != tk) || (tk && pt != tg);
      need = tk && (!hit || pt != tg);
      if (mis) exp_redir.push_back('{cyc + 1, tk ? tg : pc + 32'd4, 32'd0});
      if (need) begin
        if (model.size() > 0 && model[model.size()-1].pc == pc && !(pop && model.size() == 1)) begin
          e = model[model.size()-1];
          e.target = tg;
          model[model.size()-1] = e;
        end else begin
          model.push_back('{pc, tg});
        end
      end
    end
    if (pop) void'(model.pop_front());
  endtask

  task automatic idle(input bit stall, input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, stall, 1'b0, acc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.redirect === 1'b1) begin
        checks++;
        if (exp_redir.size() == 0 || exp_redir[0].cyc != cyc) begin
          failures++;
          $display("FAIL redirect_unexpected got pc=%h cyc=%0d", bus.redirect_pc, cyc);
        end else begin
          e = exp_redir.pop_front();
          if (bus.redirect_pc !== e.a) begin
            failures++;
            $display("FAIL redirect_pc got=%h want=%h cyc=%0d", bus.redirect_pc, e.a, cyc);
          end
        end
      end else if (exp_redir.size() > 0 && exp_redir[0].cyc <= cyc) begin
        checks++;
        failures++;
        e = exp_redir.pop_front();
        $display("FAIL redirect_missing got=0 want pc=%h cyc=%0d", e.a, cyc);
      end
      if (bus.update === 1'b1) begin
        checks++;
        if (exp_upd.size() == 0 || exp_upd[0].cyc != cyc) begin
          failures++;
          $display("FAIL update_unexpected got addr=%h target=%h cyc=%0d",
                   bus.update_addr, bus.update_target_addr, cyc);
        end else begin
          e = exp_upd.pop_front();
          if (bus.update_addr !== e.a || bus.update_target_addr !== e.b) begin
            failures++;
            $display("FAIL update_entry got=%h/%h want=%h/%h cyc=%0d",
                     bus.update_addr, bus.update_target_addr, e.a, e.b, cyc);
          end
        end
      end else if (exp_upd.size() > 0 && exp_upd[0].cyc <= cyc) begin
        checks++;
        failures++;
        e = exp_upd.pop_front();
        $display("FAIL update_missing got=0 want=%h/%h cyc=%0d", e.a, e.b, cyc);
      end
    end
  end

  initial begin
    bit          acc, hv, hk, hh, hs;
    logic [31:0] hpc, htg, hpt;
    logic [31:0] pcs [5];
    int          n;

    bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_taken = 1'b0; bus.res_target = '0;
    bus.res_pred_hit = 1'b0; bus.res_pred_target = '0; bus.upd_stall = 1'b0;
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
    mon_en = 1'b1;
    idle(1'b0, 1);
    chk("reset_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
    chk("reset_update", {31'd0, bus.update}, 32'd0);

    // Taken, BTB miss: redirect and training write one cycle later.
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, acc);
    idle(1'b0, 2);
    // Predicted taken, actually not taken: fall-through redirect, no training.
    step(1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, acc);
    idle(1'b0, 2);
    // Correct prediction.
    step(1'b1, 32'h180, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 1'b0, acc);
    idle(1'b0, 2);
    // Fall-through wraps at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b0, acc);
    idle(1'b0, 2);

    // Fill under stall, fifth is back-pressured until a slot frees.
    pcs = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pcs[i], 1'b1, pcs[i] + 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("fill_accept", {31'd0, acc}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pcs[4], 1'b1, pcs[4] + 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("full_blocks", {31'd0, acc}, 32'd0);
    end
    n = 0;
    do begin
      step(1'b1, pcs[4], 1'b1, pcs[4] + 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    chk("late_accept", {31'd0, acc}, 32'd1);
    idle(1'b0, 6);

    // Back-to-back writes to one PC collapse to a single entry.
    step(1'b1, 32'h80, 1'b1, 32'hA0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h80, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
    idle(1'b1, 2);
    idle(1'b0, 3);

    // Reset with entries queued and a redirect about to be registered.
    step(1'b1, 32'h200, 1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h210, 1'b1, 32'h910, 1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h220, 1'b1, 32'h920, 1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h230, 1'b1, 32'h930, 1'b0, 32'h0, 1'b1, 1'b1, acc);
    idle(1'b0, 1);
    chk("post_reset_ready", {31'd0, bus.res_ready}, 32'd1);
    idle(1'b0, 3);

    // Randomized traffic; unaccepted results are held stable.
    hv = 1'b0; acc = 1'b1;
    hpc = '0; htg = '0; hpt = '0; hk = 1'b0; hh = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(hv && !acc)) begin
        hv  = ($urandom_range(0, 3) != 0);
        hpc = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
        hk  = 1'($urandom_range(0, 1));
        htg = 32'h2000 + (32'($urandom_range(0, 3)) << 4);
        hh  = 1'($urandom_range(0, 1));
        hpt = ($urandom_range(0, 1) != 0) ? htg : 32'h2000 + (32'($urandom_range(0, 3)) << 4);
      end
      hs = ($urandom_range(0, 2) == 0);
      step(hv, hpc, hk, htg, hh, hpt, hs, 1'b0, acc);
    end

    n = 0;
    while ((model.size() > 0 || exp_upd.size() > 0 || exp_redir.size() > 0) && n < 50) begin
      idle(1'b0, 1);
      n++;
    end
    idle(1'b0, 2);
    chk("drain_updates_left", exp_upd.size(), 32'd0);
    chk("drain_redirects_left", exp_redir.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
